// File: rtl/vec_norm_seq.sv
// Sequential L2-norm engine: one shared squarer accumulates N_CH elements,
// then a bit-serial restoring root yields floor(sqrt(sum of squares)).
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   input handshake; in_vec holds N_CH packed elements
//   out_valid/out_ready output handshake; result held until accepted
//   magnitude           floor(sqrt(sumsq))
//   sumsq               sum of squares of the accepted vector
//   busy                high while accumulating or taking the root
module vec_norm_seq #(
  parameter int N_CH   = 9,
  parameter int DATA_W = 10,
  parameter bit SIGNED = 1'b0,
  localparam int ACC_W = 2*DATA_W + $clog2(N_CH),
  localparam int OUT_W = (ACC_W+1)/2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_CH*DATA_W-1:0] in_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       magnitude,
  output logic [ACC_W-1:0]       sumsq,
  output logic                   busy
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(OUT_W+1);
  localparam int PRD_W = 2*DATA_W;
  localparam int RAD_W = 2*OUT_W;
  localparam int REM_W = OUT_W+2;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    ROOT,
    DONE
  } state_t;

  state_t                 state;
  logic [N_CH*DATA_W-1:0] vec_r;
  logic [IDX_W-1:0]       idx;
  logic [CNT_W-1:0]       cnt;
  logic [ACC_W-1:0]       acc;
  logic [RAD_W-1:0]       rad;
  logic [REM_W-1:0]       rem;
  logic [OUT_W-1:0]       root;

  logic [DATA_W-1:0]      elem;
  logic [DATA_W-1:0]      mag;
  logic [PRD_W-1:0]       sq;
  logic [ACC_W-1:0]       acc_nxt;
  logic [REM_W-1:0]       rem_sh;
  logic [REM_W-1:0]       trial;
  logic                   fit;
  logic [REM_W-1:0]       rem_nxt;
  logic [OUT_W-1:0]       root_nxt;
  logic                   idx_last;

  always_comb begin
    elem = vec_r[int'(idx)*DATA_W +: DATA_W];
    mag  = elem;
    // Unsigned negate of the most negative value wraps to 2^(DATA_W-1),
    // which is the correct magnitude in DATA_W unsigned bits.
    if (SIGNED && elem[DATA_W-1])
      mag = -elem;
    sq       = PRD_W'(mag) * PRD_W'(mag);
    acc_nxt  = acc + ACC_W'(sq);
    idx_last = (idx == IDX_W'(N_CH-1));
    // Restoring root step: bring down two radicand bits, try 4r+1.
    rem_sh   = {rem[REM_W-3:0], rad[RAD_W-1 -: 2]};
    trial    = {root, 2'b01};
    fit      = (rem_sh >= trial);
    rem_nxt  = fit ? (rem_sh - trial) : rem_sh;
    root_nxt = (root << 1) | OUT_W'(fit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      magnitude <= '0;
      sumsq     <= '0;
      vec_r     <= '0;
      idx       <= '0;
      cnt       <= '0;
      acc       <= '0;
      rad       <= '0;
      rem       <= '0;
      root      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= ACCUM;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            vec_r    <= in_vec;
            acc      <= '0;
            idx      <= '0;
          end
        end
        ACCUM: begin
          acc <= acc_nxt;
          idx <= idx + 1'b1;
          if (idx_last) begin
            state <= ROOT;
            rad   <= RAD_W'(acc_nxt);
            rem   <= '0;
            root  <= '0;
            cnt   <= CNT_W'(OUT_W-1);
          end
        end
        ROOT: begin
          rad  <= rad << 2;
          rem  <= rem_nxt;
          root <= root_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            magnitude <= root_nxt;
            sumsq     <= acc;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_norm_seq.sv
// Directed bench for vec_norm_seq: unsigned and signed instances,
// scoreboard of expected results checked at each output handshake.
module tb_vec_norm_seq;

  localparam int NC = 9;
  localparam int DW = 10;
  localparam int AW = 24;
  localparam int OW = 12;
  localparam int VW = NC*DW;

  logic          clk;
  logic          rst_n;
  logic          in_valid[2];
  logic          in_ready[2];
  logic [VW-1:0] in_vec[2];
  logic          out_valid[2];
  logic          out_ready[2];
  logic [OW-1:0] magnitude[2];
  logic [AW-1:0] sumsq[2];
  logic          busy[2];

  int nvec;
  int nerr;

  typedef struct {
    longint s;
    longint m;
  } exp_t;

  exp_t sb[2][$];

  vec_norm_seq #(.N_CH(NC), .DATA_W(DW), .SIGNED(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_vec(in_vec[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .magnitude(magnitude[0]), .sumsq(sumsq[0]),
    .busy(busy[0])
  );

  vec_norm_seq #(.N_CH(NC), .DATA_W(DW), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_vec(in_vec[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .magnitude(magnitude[1]), .sumsq(sumsq[1]),
    .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack(input int a0, input int a1,
                                         input int rest);
    logic [VW-1:0] v;
    for (int i = 0; i < NC; i++)
      v[i*DW +: DW] = DW'(rest);
    v[0 +: DW]  = DW'(a0);
    v[DW +: DW] = DW'(a1);
    return v;
  endfunction

  function automatic exp_t model(input int sel, input logic [VW-1:0] v);
    exp_t e;
    longint x;
    logic [DW-1:0] el;
    e.s = 0;
    for (int i = 0; i < NC; i++) begin
      el = v[i*DW +: DW];
      x = longint'(el);
      if (sel == 1 && el[DW-1])
        x = x - (longint'(1) << DW);
      e.s += x * x;
    end
    e.m = 0;
    while ((e.m + 1) * (e.m + 1) <= e.s)
      e.m++;
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input logic [VW-1:0] v);
    in_vec[sel]   = v;
    in_valid[sel] = 1'b1;
    chk("in_ready_idle", 64'(in_ready[sel]), 64'd1);
    tick();
    sb[sel].push_back(model(sel, v));
    in_valid[sel] = 1'b0;
    chk("busy_after_accept", 64'(busy[sel]), 64'd1);
    chk("in_ready_busy", 64'(in_ready[sel]), 64'd0);
  endtask

  task automatic wait_out(input int sel);
    int n;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (out_valid[sel]) begin
        n = i;
        break;
      end
    end
    chk("latency", 64'(n), 64'd21);
  endtask

  task automatic take(input int sel);
    exp_t e;
    if (sb[sel].size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb[sel].pop_front();
    chk("sumsq", 64'(sumsq[sel]), 64'(e.s));
    chk("magnitude", 64'(magnitude[sel]), 64'(e.m));
    chk("busy_done", 64'(busy[sel]), 64'd0);
    out_ready[sel] = 1'b1;
    tick();
    out_ready[sel] = 1'b0;
    chk("out_valid_drop", 64'(out_valid[sel]), 64'd0);
    chk("in_ready_back", 64'(in_ready[sel]), 64'd1);
    chk("mag_kept", 64'(magnitude[sel]), 64'(e.m));
  endtask

  task automatic run(input int sel, input logic [VW-1:0] v);
    send(sel, v);
    wait_out(sel);
    take(sel);
  endtask

  task automatic chk_reset(input int sel);
    chk("rst_in_ready", 64'(in_ready[sel]), 64'd1);
    chk("rst_out_valid", 64'(out_valid[sel]), 64'd0);
    chk("rst_busy", 64'(busy[sel]), 64'd0);
    chk("rst_magnitude", 64'(magnitude[sel]), 64'd0);
    chk("rst_sumsq", 64'(sumsq[sel]), 64'd0);
  endtask

  task automatic mid_reset(input int cycles);
    send(0, pack(1023, 1023, 1023));
    repeat (cycles) tick();
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    void'(sb[0].pop_front());
    #2;
    rst_n = 1'b1;
    tick();
    chk_reset(0);
    run(0, pack(3, 4, 0));
  endtask

  logic [OW-1:0] hm;
  logic [AW-1:0] hs;

  initial begin
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_valid[s]  = 1'b0;
      out_ready[s] = 1'b0;
      in_vec[s]    = '0;
    end
    #12;
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;
    tick();

    run(0, pack(1, 1, 1));
    run(0, pack(1023, 1023, 1023));
    run(0, pack(3, 4, 0));
    run(0, pack(1, 1, 0));
    run(0, pack(0, 0, 0));
    run(0, pack(1000, 7, 513));

    run(1, pack(512, 512, 512));
    run(1, pack(1021, 4, 0));
    run(1, pack(511, 1023, 3));

    // result held while downstream stalls; input side ignored
    send(0, pack(5, 12, 0));
    wait_out(0);
    hm = magnitude[0];
    hs = sumsq[0];
    for (int i = 0; i < 50; i++) begin
      in_valid[0] = 1'(i % 2);
      in_vec[0]   = VW'({$urandom, $urandom, $urandom});
      out_ready[1] = 1'(i % 3 == 0);
      tick();
      chk("hold_valid", 64'(out_valid[0]), 64'd1);
      chk("hold_in_ready", 64'(in_ready[0]), 64'd0);
      chk("hold_mag", 64'(magnitude[0]), 64'(hm));
      chk("hold_sumsq", 64'(sumsq[0]), 64'(hs));
    end
    in_valid[0]  = 1'b0;
    out_ready[1] = 1'b0;
    chk("idle_s_untouched", 64'(in_ready[1]), 64'd1);
    take(0);
    tick();
    chk("one_handoff", 64'(out_valid[0]), 64'd0);
    run(0, pack(6, 8, 0));

    mid_reset(4);
    mid_reset(15);

    chk("sb_drained", 64'(sb[0].size() + sb[1].size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
